ctrl_resolve_buffer: RTL and testbench

Sits directly downstream of the control ALU in the execute stage. Captures each resolved control instruction: PC, computed next PC, direction, mispredict and predicted flags.
- Produces a registered fetch-redirect pulse on mispredict.
- Buffers predictor/BTB training records in a FIFO drained through a valid/ready handshake.
- Decouples execute, which can never stall, from predictor update bandwidth.

---
 rtl/ctrl_resolve_buffer_pkg.sv | 25 ++
 rtl/ctrl_resolve_buffer_if.sv | 41 ++++
 rtl/ctrl_resolve_buffer_upd_fifo.sv | 46 ++++
 rtl/ctrl_resolve_buffer.sv | 83 ++++++++
 tb/tb_ctrl_resolve_buffer.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_resolve_buffer_pkg.sv
// Shared types for the control-resolve buffer: control kinds and the training record.
// SIZE_PC sets the default PC width and falls back to 32 when it is not defined.
`ifndef SIZE_PC
`define SIZE_PC 32
`endif

package ctrl_resolve_buffer_pkg;
  localparam int PKT_PC_W = `SIZE_PC;

  typedef enum logic [1:0] {
    CT_BRANCH = 2'd0,
    CT_JAL    = 2'd1,
    CT_JALR   = 2'd2,
    CT_OTHER  = 2'd3
  } ctrlType_e;

  typedef struct packed {
    logic [PKT_PC_W-1:0] pc;
    logic [PKT_PC_W-1:0] npc;
    logic                dir;
    logic                misp;
    logic                cond;
    ctrlType_e           ctype;
  } ctrlUpdPkt;
endpackage

// File: rtl/ctrl_resolve_buffer_if.sv
// Execute-side resolve inputs, redirect outputs and the predictor training port.
interface ctrl_resolve_buffer_if #(
  parameter int DEPTH  = 8,
  parameter int PC_W   = `SIZE_PC,
  parameter int DROP_W = 16
);
  logic                   ctrlValid_i;
  logic [PC_W-1:0]        pc_i;
  logic [PC_W-1:0]        nextPC_i;
  logic                   direction_i;
  logic                   mispredict_i;
  logic                   isPredicted_i;
  logic [1:0]             ctrlType_i;
  logic                   flush_i;
  logic                   redirect_o;
  logic [PC_W-1:0]        redirectPC_o;
  logic                   updValid_o;
  logic                   updReady_i;
  logic [PC_W-1:0]        updPC_o;
  logic [PC_W-1:0]        updNPC_o;
  logic                   updDir_o;
  logic                   updMisp_o;
  logic                   updCond_o;
  logic [1:0]             updType_o;
  logic [$clog2(DEPTH):0] count_o;
  logic [DROP_W-1:0]      dropCnt_o;

  modport master (
    output ctrlValid_i, pc_i, nextPC_i, direction_i, mispredict_i, isPredicted_i,
           ctrlType_i, flush_i, updReady_i,
    input  redirect_o, redirectPC_o, updValid_o, updPC_o, updNPC_o, updDir_o,
           updMisp_o, updCond_o, updType_o, count_o, dropCnt_o
  );

  modport slave (
    input  ctrlValid_i, pc_i, nextPC_i, direction_i, mispredict_i, isPredicted_i,
           ctrlType_i, flush_i, updReady_i,
    output redirect_o, redirectPC_o, updValid_o, updPC_o, updNPC_o, updDir_o,
           updMisp_o, updCond_o, updType_o, count_o, dropCnt_o
  );
endinterface

// File: rtl/ctrl_resolve_buffer_upd_fifo.sv
// DEPTH-entry FIFO of training records; head output reads as zero while empty.
module ctrl_upd_fifo
  import ctrl_resolve_buffer_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  ctrlUpdPkt              din,
  input  logic                   pop,
  output ctrlUpdPkt              dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  ctrlUpdPkt       mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;

  assign empty = (count == '0);
  assign full  = (count == ($clog2(DEPTH)+1)'(DEPTH));
  assign dout  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointers are exactly log2(DEPTH) wide, so wrap is free.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/ctrl_resolve_buffer.sv
// Captures resolved control instructions: registered fetch redirect plus a training FIFO.
// Optional same-cycle empty-FIFO bypass under CTRL_RESOLVE_BYPASS_EN.
module ctrl_resolve_buffer
  import ctrl_resolve_buffer_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int PC_W   = `SIZE_PC,
  parameter int DROP_W = 16
) (
  input logic                  clk,
  input logic                  reset,
  ctrl_resolve_buffer_if.slave bus
);
  ctrlUpdPkt              in_pkt, head, out_pkt;
  logic                   enq_ok, push, pop, drop, byp_take, full, empty;
  logic [$clog2(DEPTH):0] count;
  logic                   redirect_q;
  logic [PC_W-1:0]        redirect_pc_q;
  logic [DROP_W-1:0]      drop_cnt;

  assign in_pkt = '{pc: bus.pc_i, npc: bus.nextPC_i, dir: bus.direction_i,
                    misp: bus.mispredict_i, cond: bus.isPredicted_i,
                    ctype: ctrlType_e'(bus.ctrlType_i)};

  assign enq_ok = bus.ctrlValid_i & (bus.ctrlType_i != 2'(CT_OTHER));
  assign pop    = ~empty & bus.updReady_i;

`ifdef CTRL_RESOLVE_BYPASS_EN
  logic byp;
  assign byp            = empty & enq_ok;
  assign byp_take       = byp & bus.updReady_i;
  assign out_pkt        = byp ? in_pkt : head;
  assign bus.updValid_o = ~empty | byp;
`else
  assign byp_take       = 1'b0;
  assign out_pkt        = head;
  assign bus.updValid_o = ~empty;
`endif

  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
  assign push = enq_ok & ~byp_take & (~full | pop);
  assign drop = enq_ok & full & ~pop;

  ctrl_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .din  (in_pkt),
    .pop  (pop),
    .dout (head),
    .full (full),
    .empty(empty),
    .count(count)
  );

  // flush cancels any redirect for the next cycle; the target register holds otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      redirect_q <= bus.ctrlValid_i & bus.mispredict_i & ~bus.flush_i;
      if (bus.ctrlValid_i & bus.mispredict_i & ~bus.flush_i)
        redirect_pc_q <= bus.nextPC_i;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                       drop_cnt <= '0;
    else if (drop && drop_cnt != '1)  drop_cnt <= drop_cnt + 1'b1;
  end

  assign bus.redirect_o   = redirect_q;
  assign bus.redirectPC_o = redirect_pc_q;
  assign bus.updPC_o      = out_pkt.pc;
  assign bus.updNPC_o     = out_pkt.npc;
  assign bus.updDir_o     = out_pkt.dir;
  assign bus.updMisp_o    = out_pkt.misp;
  assign bus.updCond_o    = out_pkt.cond;
  assign bus.updType_o    = 2'(out_pkt.ctype);
  assign bus.count_o      = count;
  assign bus.dropCnt_o    = drop_cnt;
endmodule

// File: tb/tb_ctrl_resolve_buffer.sv
// Directed plus random stimulus against a queue-based reference model of the resolve buffer.
module tb_ctrl_resolve_buffer;
  import ctrl_resolve_buffer_pkg::*;

  localparam int DEPTH  = 8;
  localparam int PC_W   = `SIZE_PC;
  localparam int DROP_W = 16;
`ifdef CTRL_RESOLVE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  ctrl_resolve_buffer_if #(.DEPTH(DEPTH), .PC_W(PC_W), .DROP_W(DROP_W)) bus ();

  ctrl_resolve_buffer #(.DEPTH(DEPTH), .PC_W(PC_W), .DROP_W(DROP_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  ctrlUpdPkt       q[$];
  int              m_drop = 0;
  bit              m_redir = 0;
  logic [PC_W-1:0] m_rpc = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input bit v, input logic [PC_W-1:0] pc, input logic [PC_W-1:0] npc,
                        input bit dir, input bit misp, input bit cond, input logic [1:0] ty,
                        input bit fl, input bit rdy);
    bus.ctrlValid_i = v;  bus.pc_i = pc;  bus.nextPC_i = npc;
    bus.direction_i = dir; bus.mispredict_i = misp; bus.isPredicted_i = cond;
    bus.ctrlType_i = ty;  bus.flush_i = fl; bus.updReady_i = rdy;
  endtask

  task automatic idle(input bit rdy);
    set_in(0, '0, '0, 0, 0, 0, 2'd0, 0, rdy);
  endtask

  // Check current outputs against the model, then advance one clock with the current inputs.
  task automatic cyc();
    ctrlUpdPkt inp, exp_rec;
    bit enq, byp, exp_v;
    #1;
    inp = '{pc: bus.pc_i, npc: bus.nextPC_i, dir: bus.direction_i, misp: bus.mispredict_i,
            cond: bus.isPredicted_i, ctype: ctrlType_e'(bus.ctrlType_i)};
    enq   = bus.ctrlValid_i && bus.ctrlType_i != 2'd3;
    byp   = BYP && q.size() == 0 && enq;
    exp_v = (q.size() != 0) || byp;
    exp_rec = byp ? inp : (q.size() != 0 ? q[0] : '0);
    chk("updValid", bus.updValid_o, exp_v);
    chk("count", bus.count_o, q.size());
    chk("dropCnt", bus.dropCnt_o, m_drop);
    chk("redirect", bus.redirect_o, m_redir);
    chk("redirectPC", bus.redirectPC_o, m_rpc);
    chk("updPC", bus.updPC_o, exp_rec.pc);
    chk("updNPC", bus.updNPC_o, exp_rec.npc);
    chk("updFlags", {bus.updDir_o, bus.updMisp_o, bus.updCond_o, bus.updType_o},
        {exp_rec.dir, exp_rec.misp, exp_rec.cond, 2'(exp_rec.ctype)});
    @(posedge clk);
    if (byp && bus.updReady_i) begin
      // consumed straight from the inputs
    end else begin
      if (q.size() != 0 && bus.updReady_i) void'(q.pop_front());
      if (enq) begin
        if (q.size() < DEPTH) q.push_back(inp);
        else if (m_drop < (1 << DROP_W) - 1) m_drop++;
      end
    end
    m_redir = bus.ctrlValid_i && bus.mispredict_i && !bus.flush_i;
    if (m_redir) m_rpc = bus.nextPC_i;
    @(negedge clk);
  endtask

  task automatic model_reset();
    q.delete();
    m_drop = 0; m_redir = 0; m_rpc = '0;
  endtask

  initial begin
    idle(0);
    repeat (2) @(negedge clk);
    chk("rst_valid", bus.updValid_o, 0);
    chk("rst_count", bus.count_o, 0);
    chk("rst_redirect", bus.redirect_o, 0);
    chk("rst_drop", bus.dropCnt_o, 0);
    reset = 1'b1;
    @(negedge clk);

    // 1: mispredicted JALR
    set_in(1, 32'h1000, 32'h2040, 1, 1, 0, 2'd2, 0, 0);
    cyc();
    idle(0);
    chk("t1_redirect", bus.redirect_o, 1);
    chk("t1_rpc", bus.redirectPC_o, 32'h2040);
    chk("t1_type", bus.updType_o, 2);
    chk("t1_count", bus.count_o, 1);
    cyc();
    chk("t1_redirect_off", bus.redirect_o, 0);

    // 2: mispredict under flush
    set_in(1, 32'h1100, 32'h3000, 1, 1, 1, 2'd0, 1, 0);
    cyc();
    idle(0);
    chk("t2_redirect", bus.redirect_o, 0);
    chk("t2_count", bus.count_o, 2);
    idle(1);
    repeat (3) cyc();

    // 3: overflow and in-order drain
    for (int i = 0; i < 10; i++) begin
      set_in(1, 32'h100 + 4*i, 32'h100 + 4*i + 4, 0, 0, 1, 2'd0, 0, 0);
      cyc();
    end
    idle(0);
    chk("t3_count", bus.count_o, 8);
    chk("t3_drop", bus.dropCnt_o, 2);
    idle(1);
    for (int i = 0; i < 8; i++) begin
      #1 chk("t3_order", bus.updPC_o, 32'h100 + 4*i);
      cyc();
    end
    chk("t3_empty", bus.updValid_o, 0);

    // 4: full with simultaneous push and pop
    for (int i = 0; i < 8; i++) begin
      set_in(1, 32'h200 + 4*i, 32'h0, 1, 0, 1, 2'd0, 0, 0);
      cyc();
    end
    set_in(1, 32'h300, 32'h304, 1, 0, 0, 2'd1, 0, 1);
    cyc();
    idle(0);
    chk("t4_count", bus.count_o, 8);
    chk("t4_drop", bus.dropCnt_o, 2);
    idle(1);
    repeat (8) cyc();

    // 5: fence, no enqueue, no redirect
    set_in(1, 32'h400, 32'h404, 0, 0, 0, 2'd3, 0, 0);
    cyc();
    idle(0);
    chk("t5_count", bus.count_o, 0);
    chk("t5_redirect", bus.redirect_o, 0);

    // 6: reset mid-operation with a pending redirect
    for (int i = 0; i < 5; i++) begin
      set_in(1, 32'h500 + 4*i, 32'h0, 0, 0, 1, 2'd0, 0, 0);
      cyc();
    end
    set_in(1, 32'h600, 32'h7000, 1, 1, 0, 2'd3, 0, 0);
    cyc();
    idle(0);
    chk("t6_pending", bus.redirect_o, 1);
    #2 reset = 1'b0;
    #1;
    model_reset();
    chk("t6_rst_valid", bus.updValid_o, 0);
    chk("t6_rst_count", bus.count_o, 0);
    chk("t6_rst_redirect", bus.redirect_o, 0);
    chk("t6_rst_rpc", bus.redirectPC_o, 0);
    chk("t6_rst_pc", bus.updPC_o, 0);
    @(negedge clk);
    reset = 1'b1;
    set_in(1, 32'h800, 32'h804, 1, 0, 1, 2'd0, 0, 1);
    #1 chk("t6_first_same", bus.updValid_o, BYP);
    cyc();
    idle(1);
    #1 chk("t6_first_next", bus.updValid_o, !BYP);
    cyc();

    // random phase
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 9) < 7, $urandom, $urandom, 1'($urandom), $urandom_range(0, 9) < 3,
             1'($urandom), 2'($urandom), $urandom_range(0, 9) < 2,
             $urandom_range(0, 9) < ((i / 100) % 2 ? 2 : 7));
      cyc();
    end
    idle(1);
    repeat (10) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
